bbp_update_queue: RTL and testbench

Buffers resolved conditional-branch outcomes from the execute/resolve stage and drains them into the bimodal predictor's write port, at most one update per cycle. It sits directly upstream of the bimodal predictor table. It decouples bursts of branch resolutions from the single-ported counter update. Entries are drained strictly in resolution order, so counter updates to the same PC are never reordered.

---
 rtl/bbp_update_queue_if.sv | 27 ++
 rtl/bbp_update_queue.sv | 123 ++++++++++++
 tb/tb_bbp_update_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bbp_update_queue_if.sv
// +----------------------------------------------------------------------+
// | bbp_update_queue_if : resolve-side offer and predictor write bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface bbp_update_queue_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_PC;
    logic        upd_taken;
    logic        bbp_write;
    logic [31:0] bbp_PC_write_address;
    logic        bbp_write_data;

    modport master (
        output upd_valid, upd_PC, upd_taken,
        input  upd_ready, bbp_write, bbp_PC_write_address, bbp_write_data
    );

    modport slave (
        input  upd_valid, upd_PC, upd_taken,
        output upd_ready, bbp_write, bbp_PC_write_address, bbp_write_data
    );
endinterface

`default_nettype wire

// File: rtl/bbp_update_queue.sv
// +----------------------------------------------------------------------+
// | bbp_update_queue : in-order FIFO of resolved branch outcomes feeding  |
// | the bimodal predictor write port. Optional macro: BBP_UPDQ_BYPASS_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bbp_update_queue #(
    parameter int DEPTH = 8
) (
    input  wire logic                     CLK,
    input  wire logic                     RESET,
    input  wire logic                     hold,
    input  wire logic                     clear,
    bbp_update_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic          taken_mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;

    always_comb begin
        w_full  = (count_q == FULL_COUNT);
        w_empty = (count_q == '0);
        w_ready = !w_full && !clear;
`ifdef BBP_UPDQ_BYPASS_EN
        // An offer into an empty, undrained queue goes straight to the predictor.
        w_bypass = w_empty && bus.upd_valid && !hold && !clear;
`else
        w_bypass = 1'b0;
`endif
        w_pop  = !w_empty && !hold && !clear;
        w_push = bus.upd_valid && w_ready && !w_bypass;
    end

    always_comb begin
        bus.upd_ready            = w_ready;
        bus.bbp_write            = w_pop || w_bypass;
        bus.bbp_PC_write_address = 32'h0;
        bus.bbp_write_data       = 1'b0;
        if (w_pop) begin
            bus.bbp_PC_write_address = pc_mem_q[rd_ptr_q];
            bus.bbp_write_data       = taken_mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            bus.bbp_PC_write_address = bus.upd_PC;
            bus.bbp_write_data       = bus.upd_taken;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (bus.upd_valid && !w_ready) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= bus.upd_PC;
            taken_mem_q[wr_ptr_q] <= bus.upd_taken;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bbp_update_queue.sv
// +----------------------------------------------------------------------+
// | tb_bbp_update_queue : directed scoreboard bench for bbp_update_queue  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bbp_update_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
    } ent_t;

    logic       CLK;
    logic       RESET;
    logic       hold;
    logic       clear;
    logic [3:0] count;
    logic       overflow;

    bbp_update_queue_if u_if ();

    bbp_update_queue #(.DEPTH(8)) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .hold     (hold),
        .clear    (clear),
        .bus      (u_if),
        .count    (count),
        .overflow (overflow)
    );

    int   errors = 0;
    int   checks = 0;
    ent_t sb   [$];
    ent_t wlog [$];
    logic m_ovf;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs before the edge, then advance the scoreboard.
    task automatic cycle();
        logic exp_ready;
        logic exp_wr;
        logic byp;
        ent_t e;
        @(negedge CLK);
        exp_ready = (sb.size() != 8) && !clear;
        byp = 1'b0;
`ifdef BBP_UPDQ_BYPASS_EN
        byp = (sb.size() == 0) && u_if.upd_valid && !hold && !clear;
`endif
        exp_wr = ((sb.size() != 0) && !hold && !clear) || byp;
        chk("upd_ready", 32'(u_if.upd_ready), 32'(exp_ready));
        chk("bbp_write", 32'(u_if.bbp_write), 32'(exp_wr));
        chk("count",     32'(count),          32'(sb.size()));
        chk("overflow",  32'(overflow),       32'(m_ovf));
        if (exp_wr) begin
            e = byp ? ent_t'{u_if.upd_PC, u_if.upd_taken} : sb[0];
            chk("wr_addr", u_if.bbp_PC_write_address, e.pc);
            chk("wr_data", 32'(u_if.bbp_write_data),  32'(e.tk));
            wlog.push_back(ent_t'{u_if.bbp_PC_write_address, u_if.bbp_write_data});
        end else begin
            chk("idle_addr", u_if.bbp_PC_write_address, 32'h0);
            chk("idle_data", 32'(u_if.bbp_write_data),  32'h0);
        end
        @(posedge CLK);
        if (clear) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            if (u_if.upd_valid && !exp_ready) m_ovf = 1'b1;
            if (exp_wr && !byp) void'(sb.pop_front());
            if (u_if.upd_valid && exp_ready && !byp)
                sb.push_back(ent_t'{u_if.upd_PC, u_if.upd_taken});
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic tk);
        u_if.upd_valid = 1'b1;
        u_if.upd_PC    = pc;
        u_if.upd_taken = tk;
        cycle();
    endtask

    task automatic idle(input int n);
        u_if.upd_valid = 1'b0;
        u_if.upd_PC    = 32'h0;
        u_if.upd_taken = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        logic [2:0] exp_tk;
        RESET          = 1'b0;
        hold           = 1'b0;
        clear          = 1'b0;
        u_if.upd_valid = 1'b0;
        u_if.upd_PC    = 32'h0;
        u_if.upd_taken = 1'b0;
        m_ovf          = 1'b0;

        // Reset state
        #7;
        chk("rst_count",     32'(count),                  32'h0);
        chk("rst_overflow",  32'(overflow),               32'h0);
        chk("rst_ready",     32'(u_if.upd_ready),         32'h1);
        chk("rst_write",     32'(u_if.bbp_write),         32'h0);
        chk("rst_addr",      u_if.bbp_PC_write_address,   32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Single offer
        offer(32'h0000_031C, 1'b1);
`ifndef BBP_UPDQ_BYPASS_EN
        chk("single_count_after_push", 32'(count), 32'h1);
`endif
        idle(2);
        chk("single_count_drained", 32'(count), 32'h0);

        // Fill under hold, then overflow on the ninth offer
        hold = 1'b1;
        for (int i = 0; i < 9; i++) offer(32'h100 + 32'(4 * i), i[0]);
        idle(1);
        chk("fill_count",    32'(count),    32'h8);
        chk("fill_overflow", 32'(overflow), 32'h1);
        wlog.delete();
        hold = 1'b0;
        idle(9);
        chk("fill_nwrites", 32'(wlog.size()), 32'h8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk("fill_order", wlog[i].pc, 32'h100 + 32'(4 * i));

        // Streaming at occupancy 3
        hold = 1'b1;
        for (int i = 0; i < 3; i++) offer(32'h200 + 32'(4 * i), 1'b1);
        hold = 1'b0;
        wlog.delete();
        for (int i = 3; i < 23; i++) begin
            offer(32'h200 + 32'(4 * i), i[1]);
            chk("stream_count", 32'(count), 32'h3);
        end
        idle(4);
        chk("stream_nwrites", 32'(wlog.size()), 32'd23);
        for (int i = 0; i < 23 && i < wlog.size(); i++)
            chk("stream_order", wlog[i].pc, 32'h200 + 32'(4 * i));

        // Same-PC ordering
        wlog.delete();
        exp_tk = 3'b110;
        offer(32'h31C, 1'b1);
        offer(32'h31C, 1'b1);
        offer(32'h31C, 1'b0);
        idle(3);
        chk("samepc_nwrites", 32'(wlog.size()), 32'h3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            chk("samepc_addr", wlog[i].pc, 32'h31C);
            chk("samepc_data", 32'(wlog[i].tk), 32'(exp_tk[2 - i]));
        end

        // clear at count 5 with a simultaneous offer (overflow still set from earlier)
        hold = 1'b1;
        for (int i = 0; i < 5; i++) offer(32'h300 + 32'(4 * i), 1'b0);
        clear = 1'b1;
        offer(32'hDEAD_BEE0, 1'b1);
        clear = 1'b0;
        hold  = 1'b0;
        chk("clear_count",    32'(count),    32'h0);
        chk("clear_overflow", 32'(overflow), 32'h0);
        wlog.delete();
        idle(2);
        chk("clear_nwrites", 32'(wlog.size()), 32'h0);

        // Asynchronous reset mid-drain at count 4
        hold = 1'b1;
        for (int i = 0; i < 4; i++) offer(32'h400 + 32'(4 * i), 1'b1);
        u_if.upd_valid = 1'b0;
        hold = 1'b0;
        #2;
        chk("prereset_write", 32'(u_if.bbp_write), 32'h1);
        RESET = 1'b0;
        #1;
        chk("async_write", 32'(u_if.bbp_write),       32'h0);
        chk("async_addr",  u_if.bbp_PC_write_address, 32'h0);
        chk("async_count", 32'(count),                32'h0);
        sb.delete();
        m_ovf = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("postreset_count", 32'(count),          32'h0);
        chk("postreset_ready", 32'(u_if.upd_ready), 32'h1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
